// File: rtl/vga_scan_ctrl_if.sv
// rtl/vga_scan_ctrl_if.sv - VRAM port-A read bus between the scan controller and VRAM
`timescale 1ns/1ps
interface vga_scan_ctrl_if;
  logic [13:0] vram_addr;
  logic        vram_en;
  logic        vram_ssr;
  logic        vram_dout_r;
  logic        vram_dout_g;
  logic        vram_dout_b;

  // Scan controller side: issues read addresses, receives pixel colour
  modport master (
    output vram_addr, vram_en, vram_ssr,
    input  vram_dout_r, vram_dout_g, vram_dout_b
  );

  // VRAM side: serves reads
  modport slave (
    input  vram_addr, vram_en, vram_ssr,
    output vram_dout_r, vram_dout_g, vram_dout_b
  );
endinterface

// File: rtl/vga_scan_ctrl.sv
// rtl/vga_scan_ctrl.sv - VGA scan timing, scaled VRAM fetch and registered pin drive
`timescale 1ns/1ps
module vga_scan_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SCALE    = 5
) (
  input  logic            clk,
  input  logic            reset,
  vga_scan_ctrl_if.master vram,
  output logic            vga_r,
  output logic            vga_g,
  output logic            vga_b,
  output logic            vga_hsync,
  output logic            vga_vsync,
  output logic            frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = $clog2(CLK_DIV);
  localparam int SW = $clog2(SCALE + 1);

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SUB_LAST   = SW'(SCALE - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic          pix_tick;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [SW-1:0] col_sub_q, col_sub_d, row_sub_q, row_sub_d;
  logic [6:0]    col_q, col_d, row_q, row_d;
  logic          h_wrap, v_wrap, active;

  logic [13:0]   addr_q;
  logic          en_q, ssr_q, act_f_q, fetch_vld_q;
  logic [HW-1:0] h_f_q;
  logic [VW-1:0] v_f_q;

  logic [2:0]    rgb_q;
  logic          hsync_q, vsync_q, frame_start_q;

  // Next-state for the pixel divider, scan position and VRAM scale counters.
  // Scale counters stop at the last visible column/row so col<=127, row<=95.
  always_comb begin
    pix_tick  = (div_q == DIV_LAST);
    div_d     = pix_tick ? '0 : div_q + 1'b1;
    h_wrap    = (h_cnt_q == H_LAST);
    v_wrap    = (v_cnt_q == V_LAST);
    active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    h_cnt_d   = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d   = v_cnt_q;
    col_sub_d = col_sub_q;
    col_d     = col_q;
    row_sub_d = row_sub_q;
    row_d     = row_q;
    if (h_wrap) begin
      v_cnt_d   = v_wrap ? '0 : v_cnt_q + 1'b1;
      col_sub_d = '0;
      col_d     = '0;
      if (v_wrap) begin
        row_sub_d = '0;
        row_d     = '0;
      end else if (v_cnt_q < V_ACT_LAST) begin
        if (row_sub_q == SUB_LAST) begin
          row_sub_d = '0;
          row_d     = row_q + 1'b1;
        end else begin
          row_sub_d = row_sub_q + 1'b1;
        end
      end
    end else if (h_cnt_q < H_ACT_LAST) begin
      if (col_sub_q == SUB_LAST) begin
        col_sub_d = '0;
        col_d     = col_q + 1'b1;
      end else begin
        col_sub_d = col_sub_q + 1'b1;
      end
    end
  end

  // Timing state: divider runs every clk, scan counters step on pixel ticks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      col_sub_q <= '0;
      col_q     <= '0;
      row_sub_q <= '0;
      row_q     <= '0;
    end else begin
      div_q <= div_d;
      if (pix_tick) begin
        h_cnt_q   <= h_cnt_d;
        v_cnt_q   <= v_cnt_d;
        col_sub_q <= col_sub_d;
        col_q     <= col_d;
        row_sub_q <= row_sub_d;
        row_q     <= row_d;
      end
    end
  end

  // Fetch stage: issue the VRAM read and keep a copy of the position for the output stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      en_q        <= 1'b0;
      ssr_q       <= 1'b1;
      h_f_q       <= '0;
      v_f_q       <= '0;
      act_f_q     <= 1'b0;
      fetch_vld_q <= 1'b0;
    end else if (pix_tick) begin
      if (active) begin
        addr_q <= {row_q, col_q};
      end
      en_q        <= active;
      ssr_q       <= ~active;
      h_f_q       <= h_cnt_q;
      v_f_q       <= v_cnt_q;
      act_f_q     <= active;
      fetch_vld_q <= 1'b1;
    end
  end

  // Output stage: colour and syncs from the fetched pixel; frame_start is a one-clk pulse,
  // suppressed on the first tick after reset when the fetch copy is not yet real
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q         <= 3'b000;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (pix_tick) begin
        rgb_q         <= act_f_q ? {vram.vram_dout_r, vram.vram_dout_g, vram.vram_dout_b} : 3'b000;
        hsync_q       <= ~((h_f_q >= HS_BEG) && (h_f_q < HS_END));
        vsync_q       <= ~((v_f_q >= VS_BEG) && (v_f_q < VS_END));
        frame_start_q <= fetch_vld_q && (h_f_q == '0) && (v_f_q == '0);
      end
    end
  end

  assign vram.vram_addr = addr_q;
  assign vram.vram_en   = en_q;
  assign vram.vram_ssr  = ssr_q;
  assign vga_r          = rgb_q[2];
  assign vga_g          = rgb_q[1];
  assign vga_b          = rgb_q[0];
  assign vga_hsync      = hsync_q;
  assign vga_vsync      = vsync_q;
  assign frame_start    = frame_start_q;

endmodule
